// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: zero-fills the register file after reset, then shares
// its single write port among NUM_REQ writeback sources by round-robin.
module regfile_write_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 6,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_REQ        = 3,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [ADDR_WIDTH-1:0]            rf_waddr,
    output logic                             rf_we,
    output logic [DATA_WIDTH-1:0]            rf_wdata,
    output logic                             busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CAND_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic                   rf_we_q, rf_we_d;
    logic [ADDR_WIDTH-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0]  rf_wdata_q, rf_wdata_d;

    logic [ADDR_WIDTH-1:0]  addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]  data_arr [NUM_REQ];
    logic                   gnt_found;
    logic [PTR_W-1:0]       gnt_idx;
    logic [CAND_W-1:0]      cand;
    logic [NUM_REQ-1:0]     ready_c;

    // Unpack the flattened request buses into per-requester arrays.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin search: first valid requester starting at ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + CAND_W'(k);
            if (cand >= CAND_W'(NUM_REQ)) begin
                cand = cand - CAND_W'(NUM_REQ);
            end
            if (!gnt_found && req_valid[cand[PTR_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Ready is only offered in RUN and never while reset is asserted.
    always_comb begin
        ready_c = '0;
        if (!rst && (state_q == ST_RUN) && gnt_found) begin
            ready_c[gnt_idx] = 1'b1;
        end
    end

    // Next-state and registered write-port values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        case (state_q)
            ST_CLEAR: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = cnt_q;
                rf_wdata_d = '0;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (gnt_found) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = addr_arr[gnt_idx];
                    rf_wdata_d = data_arr[gnt_idx];
                    ptr_d      = (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
                end
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RESET_STATE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign req_ready = ready_c;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign busy      = rst | (state_q == ST_CLEAR);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter (default and no-clear builds).
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [17:0] req_addr  = '0;
    logic [95:0] req_data  = '0;
    logic [2:0]  req_ready;
    logic [5:0]  rf_waddr;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic        busy;

    logic        nc_rst = 1'b1;
    logic [2:0]  nc_valid = '0;
    logic [17:0] nc_addr  = '0;
    logic [95:0] nc_data  = '0;
    logic [2:0]  nc_ready;
    logic [5:0]  nc_waddr;
    logic        nc_we;
    logic [31:0] nc_wdata;
    logic        nc_busy;

    logic [31:0] mem [64];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .rf_waddr(rf_waddr),
        .rf_we(rf_we), .rf_wdata(rf_wdata), .busy(busy)
    );

    regfile_write_arbiter #(.CLEAR_ON_RESET(1'b0)) u_nc (
        .clk(clk), .rst(nc_rst), .req_valid(nc_valid), .req_addr(nc_addr),
        .req_data(nc_data), .req_ready(nc_ready), .rf_waddr(nc_waddr),
        .rf_we(nc_we), .rf_wdata(nc_wdata), .busy(nc_busy)
    );

    // Register file model fed by the DUT write port.
    always @(posedge clk) begin
        if (rf_we) mem[rf_waddr] <= rf_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [5:0] a, input logic [31:0] d);
        req_valid[i] = v;
        req_addr[i*6 +: 6] = a;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
        rst = 1'b1;
        req_valid = 3'b111;
        step();
        step();
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b want 0", rf_we); end
        vectors++; if (rf_waddr !== 6'd0) begin miscompares++; $display("FAIL reset_waddr got %0d want 0", rf_waddr); end
        vectors++; if (rf_wdata !== 32'd0) begin miscompares++; $display("FAIL reset_wdata got %h want 0", rf_wdata); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy got %b want 1", busy); end
        vectors++; if (req_ready !== 3'b000) begin miscompares++; $display("FAIL reset_ready got %b want 000", req_ready); end
        rst = 1'b0;
    endtask

    task automatic test_clear();
        int bad;
        for (int i = 0; i < 64; i++) begin
            step();
            vectors++; if (rf_we !== 1'b1 || rf_waddr !== 6'(i) || rf_wdata !== 32'd0)
                begin miscompares++; $display("FAIL clear_write i=%0d got we=%b a=%0d d=%h want 1 %0d 0", i, rf_we, rf_waddr, rf_wdata, i); end
            vectors++; if (busy !== (i != 63)) begin miscompares++; $display("FAIL clear_busy i=%0d got %b want %b", i, busy, i != 63); end
            if (i != 63) begin
                vectors++; if (req_ready !== 3'b000) begin miscompares++; $display("FAIL clear_ready i=%0d got %b want 000", i, req_ready); end
            end
        end
        req_valid = '0;
        step();
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL clear_idle_we got %b want 0", rf_we); end
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== 32'd0) bad++;
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL clear_mem nonzero_regs got %0d want 0", bad); end
    endtask

    task automatic test_single_write();
        set_req(1, 1'b1, 6'd1, 32'hdeadbeef);
        #1;
        vectors++; if (req_ready !== 3'b010) begin miscompares++; $display("FAIL single_ready got %b want 010", req_ready); end
        step();
        set_req(1, 1'b0, 6'd0, 32'd0);
        vectors++; if (rf_we !== 1'b1 || rf_waddr !== 6'd1 || rf_wdata !== 32'hdeadbeef)
            begin miscompares++; $display("FAIL single_write got we=%b a=%0d d=%h want 1 1 deadbeef", rf_we, rf_waddr, rf_wdata); end
        step();
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL single_idle got %b want 0", rf_we); end
        vectors++; if (mem[1] !== 32'hdeadbeef) begin miscompares++; $display("FAIL single_readback got %h want deadbeef", mem[1]); end
    endtask

    task automatic test_contention();
        int g;
        // Grant requester 2 once so the pointer returns to 0.
        set_req(2, 1'b1, 6'd5, 32'h55);
        #1;
        vectors++; if (req_ready !== 3'b100) begin miscompares++; $display("FAIL prime_ready got %b want 100", req_ready); end
        step();
        set_req(0, 1'b1, 6'd2, 32'h11);
        set_req(1, 1'b1, 6'd3, 32'h22);
        set_req(2, 1'b1, 6'd4, 32'h33);
        for (int j = 0; j < 4; j++) begin
            g = j % 3;
            #1;
            vectors++; if (req_ready !== 3'(1 << g)) begin miscompares++; $display("FAIL contention_ready j=%0d got %b want %b", j, req_ready, 3'(1 << g)); end
            step();
            vectors++; if (rf_we !== 1'b1 || rf_waddr !== 6'(2 + g) || rf_wdata !== 32'(8'h11 * (g + 1)))
                begin miscompares++; $display("FAIL contention_write j=%0d got we=%b a=%0d d=%h want 1 %0d %h", j, rf_we, rf_waddr, rf_wdata, 2 + g, 8'h11 * (g + 1)); end
        end
        req_valid = '0;
        step();
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL contention_idle got %b want 0", rf_we); end
    endtask

    task automatic test_back_to_back();
        set_req(0, 1'b1, 6'd0, 32'ha0a0a0a0);
        set_req(2, 1'b1, 6'd7, 32'hc2c2c2c2);
        #1;
        vectors++; if (req_ready !== 3'b100) begin miscompares++; $display("FAIL bp_first_ready got %b want 100", req_ready); end
        step();
        set_req(2, 1'b0, 6'd0, 32'd0);
        vectors++; if (rf_we !== 1'b1 || rf_waddr !== 6'd7 || rf_wdata !== 32'hc2c2c2c2)
            begin miscompares++; $display("FAIL bp_first_write got we=%b a=%0d d=%h want 1 7 c2c2c2c2", rf_we, rf_waddr, rf_wdata); end
        #1;
        vectors++; if (req_ready !== 3'b001) begin miscompares++; $display("FAIL bp_second_ready got %b want 001", req_ready); end
        step();
        set_req(0, 1'b0, 6'd0, 32'd0);
        vectors++; if (rf_we !== 1'b1 || rf_waddr !== 6'd0 || rf_wdata !== 32'ha0a0a0a0)
            begin miscompares++; $display("FAIL bp_second_write got we=%b a=%0d d=%h want 1 0 a0a0a0a0", rf_we, rf_waddr, rf_wdata); end
        step();
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL bp_no_duplicate got %b want 0", rf_we); end
        vectors++; if (mem[0] !== 32'ha0a0a0a0 || mem[7] !== 32'hc2c2c2c2)
            begin miscompares++; $display("FAIL bp_readback got %h %h want a0a0a0a0 c2c2c2c2", mem[0], mem[7]); end
    endtask

    task automatic test_reset_mid_run();
        set_req(1, 1'b1, 6'd9, 32'h99);
        rst = 1'b1;
        #1;
        vectors++; if (req_ready !== 3'b000) begin miscompares++; $display("FAIL rr_ready_in_reset got %b want 000", req_ready); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rr_busy_in_reset got %b want 1", busy); end
        step();
        rst = 1'b0;
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL rr_we_after_reset got %b want 0", rf_we); end
        for (int i = 0; i < 64; i++) begin
            #1;
            vectors++; if (req_ready !== 3'b000) begin miscompares++; $display("FAIL rr_clear_ready i=%0d got %b want 000", i, req_ready); end
            step();
            vectors++; if (rf_we !== 1'b1 || rf_waddr !== 6'(i) || rf_wdata !== 32'd0)
                begin miscompares++; $display("FAIL rr_clear_write i=%0d got we=%b a=%0d want 1 %0d", i, rf_we, rf_waddr, i); end
        end
        vectors++; if (req_ready !== 3'b010) begin miscompares++; $display("FAIL rr_pending_ready got %b want 010", req_ready); end
        step();
        set_req(1, 1'b0, 6'd0, 32'd0);
        vectors++; if (rf_we !== 1'b1 || rf_waddr !== 6'd9 || rf_wdata !== 32'h99)
            begin miscompares++; $display("FAIL rr_pending_write got we=%b a=%0d d=%h want 1 9 99", rf_we, rf_waddr, rf_wdata); end
    endtask

    task automatic test_reset_mid_clear();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step();
        vectors++; if (rf_we !== 1'b1 || rf_waddr !== 6'd19)
            begin miscompares++; $display("FAIL rc_pre_reset got we=%b a=%0d want 1 19", rf_we, rf_waddr); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (rf_we !== 1'b0 || rf_waddr !== 6'd0)
            begin miscompares++; $display("FAIL rc_after_reset got we=%b a=%0d want 0 0", rf_we, rf_waddr); end
        for (int i = 0; i < 64; i++) begin
            step();
            vectors++; if (rf_we !== 1'b1 || rf_waddr !== 6'(i))
                begin miscompares++; $display("FAIL rc_restart i=%0d got we=%b a=%0d want 1 %0d", i, rf_we, rf_waddr, i); end
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rc_busy_done got %b want 0", busy); end
    endtask

    task automatic test_no_clear();
        nc_rst = 1'b1;
        nc_valid = 3'b001;
        nc_addr[5:0] = 6'd12;
        nc_data[31:0] = 32'h0badcafe;
        step();
        vectors++; if (nc_busy !== 1'b1 || nc_ready !== 3'b000)
            begin miscompares++; $display("FAIL nc_in_reset got busy=%b ready=%b want 1 000", nc_busy, nc_ready); end
        nc_rst = 1'b0;
        #1;
        vectors++; if (nc_busy !== 1'b0) begin miscompares++; $display("FAIL nc_busy got %b want 0", nc_busy); end
        vectors++; if (nc_ready !== 3'b001) begin miscompares++; $display("FAIL nc_ready got %b want 001", nc_ready); end
        step();
        nc_valid = '0;
        vectors++; if (nc_we !== 1'b1 || nc_waddr !== 6'd12 || nc_wdata !== 32'h0badcafe)
            begin miscompares++; $display("FAIL nc_write got we=%b a=%0d d=%h want 1 12 0badcafe", nc_we, nc_waddr, nc_wdata); end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_single_write();
        test_contention();
        test_back_to_back();
        test_reset_mid_run();
        test_reset_mid_clear();
        test_no_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Sequencer and arbiter for the single write port of the CPU register file (64 × 32-bit, 6-bit addresses). Zero-fills every register after reset, then shares the write port among NUM_REQ writeback sources (ALU, load unit, CSR/debug) using round-robin valid/ready arbitration. Sits between the execute/writeback stages and the `registers` write inputs (`waddr`, `we`, `wdata`). Read ports are untouched.

## Interface
- ADDR_WIDTH, 6: register address width; NUM_REGS = 2**ADDR_WIDTH.
- DATA_WIDTH, 32: register data width.
- NUM_REQ, 3: number of writeback requesters, ≥2.
- CLEAR_ON_RESET, 1: 1 = zero-fill all registers after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  flattened; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot or zero; transfer when valid & ready at an edge.
- rf_waddr  out  ADDR_WIDTH  to register file `waddr`; registered.
- rf_we  out  1  to register file `we`; registered.
- rf_wdata  out  DATA_WIDTH  to register file `wdata`; registered.
- busy  out  1  high while in CLEAR (or in reset).

## Operation
- States: CLEAR, RUN. Internal: clear counter `cnt` (ADDR_WIDTH bits), round-robin pointer `ptr` (0..NUM_REQ-1).
- Reset (rst high at an edge): state <= CLEAR (RUN if CLEAR_ON_RESET=0), cnt <= 0, ptr <= 0, rf_we <= 0, rf_waddr <= 0, rf_wdata <= 0. While rst is high: req_ready = 0, busy = 1.
- CLEAR, each edge: rf_we <= 1, rf_waddr <= cnt, rf_wdata <= 0, cnt <= cnt+1. If cnt == NUM_REGS-1, state <= RUN; cnt wraps to 0. req_ready = 0 throughout; busy = 1.
- RUN, arbitration (combinational):
  - Search for the first requester with req_valid set, starting at ptr and wrapping modulo NUM_REQ.
  - Assert req_ready for that requester only; all-zero if no valid.
  - req_ready may depend on req_valid. Requesters must not make valid depend on ready.
  - A requester holds valid, addr and data stable until its transfer completes.
- RUN, transfer to requester g at an edge: rf_we <= 1, rf_waddr <= req_addr[g], rf_wdata <= req_data[g], ptr <= (g+1) mod NUM_REQ.
- RUN, no transfer at an edge: rf_we <= 0; rf_waddr, rf_wdata and ptr hold.
- Address 0 is not special: writes to it pass through unchanged.
- busy = 0 in RUN.

## Timing
- Throughput: one write per cycle, sustained.
- Latency: transfer accepted at edge k → rf_we/rf_waddr/rf_wdata driven during the cycle after edge k → register committed at edge k+1. Readback through a read port is visible after edge k+1.
- Clear sequence, with rst released before edge 1:
  - Edges 1..64 present writes of 0 to addresses 0..63.
  - Last clear write commits at edge 65.
  - busy is high until edge 64 and low after it.
  - First requester transfer can occur at edge 65.
- Fairness: a requester holding valid is granted within NUM_REQ transfers.
- Reset mid-CLEAR: cnt restarts at 0 and the full clear sequence repeats.
- Reset mid-RUN with valid pending: no transfer while rst is high; rf_we is 0 the cycle after the reset edge; the pending request is granted only after the new clear completes.
- Simultaneous reset and valid at the same edge: reset wins; no transfer occurs.

## Test plan
- Clear: rst high 2 cycles then low, preload registers with nonzero values → rf_we=1 with rf_waddr 0..63 and rf_wdata=0 on consecutive cycles; busy falls after the 64th; all regfile reads return 0.
- Single write: after clear, requester 1 drives valid, addr=1, data=32'hdeadbeef → ready the same cycle; next cycle rf_we=1, rf_waddr=1, rf_wdata=deadbeef; rdata=deadbeef afterwards.
- Contention: all 3 requesters valid continuously (addrs 2,3,4; data 0x11,0x22,0x33), ptr=0 → grants in order 0,1,2,0,…, exactly one ready per cycle, three back-to-back rf writes.
- Back-pressure: requesters 0 and 2 valid, ptr=1 → requester 2 granted first; requester 0 holds stable until granted next cycle; no duplicate write.
- Reset at clear count 20 → rf_we=0 for one cycle, then the clear restarts at address 0 and runs the full 64 writes.
- CLEAR_ON_RESET=0: after rst release busy=0 immediately; a valid request is ready in the first cycle after release.
